adc_spi_interface: RTL and testbench

- Audio ADC front end on peripheral select 12, upstream of the equalizer controller, which reads its status/sample word as ADCIn.
- Accepts power-down, configuration and convert commands through an APB-style write port.
- Runs one 16-bit SPI mode-0 frame per command and returns status plus the last captured left/right sample.

---
 rtl/adc_spi_pkg.sv | 33 +++
 rtl/adc_spi_interface_spi_shift_engine.sv | 73 +++++++
 rtl/adc_spi_interface.sv | 138 +++++++++++++
 tb/tb_adc_spi_interface.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the audio ADC SPI front end: command codes,
// controller states, status-word layout and the counter sizing helper.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    CMD_CONVERT    = 2'b00,
    CMD_POWER_DOWN = 2'b01,
    CMD_CONFIG     = 2'b10,
    CMD_RESERVED   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PD    = 2'b01,
    SHIFT = 2'b10,
    GAP   = 2'b11
  } state_e;

  localparam int FRAME_BITS    = 16;
  localparam int PR_DONE_BIT   = 31;
  localparam int PR_BUSY_BIT   = 30;
  localparam int PR_PD_BIT     = 29;
  localparam int PR_CHAN_BIT   = 16;
  localparam int PR_SAMPLE_MSB = 15;

  localparam logic [31:0] PRDATA_RST = 32'h2000_0000;

  // Bits needed for a down-counter that starts at max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_spi_interface_spi_shift_engine.sv
// One 16-bit SPI mode-0 frame: SClk generation, MSB-first TX/RX shifting
// and a half-period down-counter that flags the final SClk edge.
module spi_shift_engine
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_word,
  input  logic                  MISO,
  output logic                  SClk,
  output logic                  MOSI,
  output logic [FRAME_BITS-1:0] rx_word,
  output logic                  frame_done
);

  localparam int DIV_W  = cnt_width(CLK_DIV - 1);
  localparam int HALF_W = cnt_width(2 * FRAME_BITS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic                  sclk_q;
  logic                  active_q;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic                  edge_tick;

  // One SClk edge per CLK_DIV cycles; the 32nd edge (last fall) ends the frame.
  assign edge_tick  = active_q && (div_cnt == '0);
  assign frame_done = edge_tick && (half_cnt == '0);

  // Divider, shift registers and frame bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else if (start && !active_q) begin
      div_cnt  <= DIV_W'(CLK_DIV - 1);
      half_cnt <= HALF_W'(2 * FRAME_BITS - 1);
      sclk_q   <= 1'b0;
      active_q <= 1'b1;
      tx_sr    <= tx_word;
      rx_sr    <= '0;
    end else if (active_q) begin
      if (edge_tick) begin
        div_cnt <= DIV_W'(CLK_DIV - 1);
        if (half_cnt == '0) begin
          active_q <= 1'b0;
          sclk_q   <= 1'b0;
        end else begin
          half_cnt <= half_cnt - 1'b1;
          sclk_q   <= ~sclk_q;
          // Rising edge samples MISO; falling edge advances MOSI.
          if (!sclk_q) rx_sr <= {rx_sr[FRAME_BITS-2:0], MISO};
          else         tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

  assign SClk    = sclk_q;
  assign MOSI    = active_q & tx_sr[FRAME_BITS-1];
  assign rx_word = rx_sr;

endmodule

// File: rtl/adc_spi_interface.sv
// Audio ADC front end: APB-style command port, sequencing FSM, CS_ gap
// timer and the status/sample word read by the equalizer controller.
//
// state | meaning
// IDLE  | waiting for a command; CS_ high
// PD    | one-cycle power-down command, no SPI frame
// SHIFT | SPI frame in flight; CS_ low
// GAP   | CS_ high recovery time before the next command
module adc_spi_interface
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PSel,
  input  logic        PEnable,
  input  logic        PWrite,
  input  logic [31:0] PWData,
  output logic [31:0] PRData,
  output logic        SClk,
  output logic        CS_,
  output logic        MOSI,
  input  logic        MISO,
  output logic        PowerDown
);

  localparam int GAP_W = cnt_width(CS_GAP - 1);

  state_e                state_q, state_d;
  cmd_e                  cmd;
  logic                  accept;
  logic                  start_frame;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] rx_word;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  busy;
  logic                  cs_n;
  logic                  done_q;
  logic                  pd_q;
  logic                  chan_q;
  logic                  chan_pend_q;
  logic                  conv_pend_q;
  logic [FRAME_BITS-1:0] sample_q;
  logic                  unused_pwdata;

  assign cmd           = cmd_e'(PWData[31:30]);
  assign accept        = PSel && PEnable && PWrite && (state_q == IDLE) && (cmd != CMD_RESERVED);
  assign start_frame   = accept && ((cmd == CMD_CONFIG) || (cmd == CMD_CONVERT));
  assign unused_pwdata = ^PWData[29:16];

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_shift (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start_frame),
    .tx_word    (PWData[FRAME_BITS-1:0]),
    .MISO       (MISO),
    .SClk       (SClk),
    .MOSI       (MOSI),
    .rx_word    (rx_word),
    .frame_done (frame_done)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (cmd == CMD_POWER_DOWN) ? PD : SHIFT;
      PD:    state_d = IDLE;
      SHIFT: if (frame_done) state_d = GAP;
      GAP:   if (gap_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state_q != IDLE);
    cs_n = (state_q != SHIFT);
  end

  // CS_ gap timer, loaded as the frame ends.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      gap_cnt <= '0;
    end else if ((state_q == SHIFT) && frame_done) begin
      gap_cnt <= GAP_W'(CS_GAP - 1);
    end else if ((state_q == GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Status register; the sample only moves on a completed conversion frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      done_q      <= PRDATA_RST[PR_DONE_BIT];
      pd_q        <= PRDATA_RST[PR_PD_BIT];
      chan_q      <= PRDATA_RST[PR_CHAN_BIT];
      chan_pend_q <= 1'b0;
      conv_pend_q <= 1'b0;
      sample_q    <= PRDATA_RST[PR_SAMPLE_MSB:0];
    end else begin
      if (accept) begin
        done_q      <= 1'b0;
        conv_pend_q <= (cmd == CMD_CONVERT);
        chan_pend_q <= PWData[14];
        if (cmd == CMD_POWER_DOWN) pd_q <= 1'b1;
        if (cmd == CMD_CONFIG)     pd_q <= 1'b0;
      end
      if ((state_q == SHIFT) && frame_done && conv_pend_q) begin
        sample_q <= rx_word;
        chan_q   <= chan_pend_q;
      end
      if ((state_q != IDLE) && (state_d == IDLE)) done_q <= 1'b1;
    end
  end

  // Status word assembly.
  always_comb begin
    PRData                   = '0;
    PRData[PR_DONE_BIT]      = done_q;
    PRData[PR_BUSY_BIT]      = busy;
    PRData[PR_PD_BIT]        = pd_q;
    PRData[PR_CHAN_BIT]      = chan_q;
    PRData[PR_SAMPLE_MSB:0]  = sample_q;
  end

  assign CS_       = cs_n;
  assign PowerDown = pd_q;

endmodule

// File: tb/tb_adc_spi_interface.sv
// Directed bench for adc_spi_interface: CONFIG, CONVERT, held writes,
// mid-frame reset, POWER_DOWN and reserved commands against hand values.
module tb_adc_spi_interface;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PSel = 1'b0;
  logic        PEnable = 1'b0;
  logic        PWrite = 1'b0;
  logic [31:0] PWData = '0;
  logic [31:0] PRData;
  logic        SClk;
  logic        CS_;
  logic        MOSI;
  logic        MISO = 1'b0;
  logic        PowerDown;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // SPI slave model / monitor state
  logic [15:0] miso_word = 16'h0000;
  logic [15:0] mosi_word = 16'h0000;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          total_rises = 0;
  int          cs_falls = 0;
  int          prev_fall_cyc = 0;
  int          last_fall_cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;

  int          t0;
  int          n0;
  int          r0;

  adc_spi_interface #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PSel      (PSel),
    .PEnable   (PEnable),
    .PWrite    (PWrite),
    .PWData    (PWData),
    .PRData    (PRData),
    .SClk      (SClk),
    .CS_       (CS_),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .PowerDown (PowerDown)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor and MISO driver, evaluated mid-cycle.
  always @(negedge Clk) begin
    if (!CS_ && prev_cs) begin
      cs_falls      = cs_falls + 1;
      prev_fall_cyc = last_fall_cyc;
      last_fall_cyc = cyc;
      rise_cnt      = 0;
      fall_cnt      = 0;
      mosi_word     = 16'h0000;
    end
    if (CS_) begin
      fall_cnt = 0;
    end else begin
      if (SClk && !prev_sclk) begin
        mosi_word = {mosi_word[14:0], MOSI};
        rise_cnt  = rise_cnt + 1;
      end
      if (!SClk && prev_sclk) fall_cnt = fall_cnt + 1;
    end
    if (SClk && !prev_sclk) total_rises = total_rises + 1;
    prev_sclk = SClk;
    prev_cs   = CS_;
    MISO      = (fall_cnt < 16) ? miso_word[4'(15 - fall_cnt)] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 'h%08h expected 'h%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Single-cycle write; returns in the cycle after the accept edge.
  task automatic do_write(input logic [31:0] w);
    PSel    = 1'b1;
    PEnable = 1'b1;
    PWrite  = 1'b1;
    PWData  = w;
    step(1);
    PSel    = 1'b0;
    PEnable = 1'b0;
    PWrite  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and stability
    step(3);
    Reset = 1'b0;
    chk("rst_prdata", PRData, 32'h2000_0000);
    chk("rst_cs", CS_, 1);
    chk("rst_sclk", SClk, 0);
    chk("rst_pd", PowerDown, 1);
    chk("rst_mosi", MOSI, 0);
    step(10);
    chk("rst_hold_prdata", PRData, 32'h2000_0000);
    chk("rst_hold_cs", CS_, 1);
    chk("rst_hold_rises", total_rises, 0);

    // CONFIG while powered down
    do_write(32'h8000_2570);
    chk("cfg_pd_fall", PowerDown, 0);
    chk("cfg_busy", PRData[30], 1);
    chk("cfg_cs_low", CS_, 0);
    chk("cfg_done_clr", PRData[31], 0);
    chk("cfg_mosi_first", MOSI, 0);
    step(3);
    chk("cfg_sclk_pre_rise", SClk, 0);
    step(1);
    chk("cfg_sclk_first_rise", SClk, 1);
    step(125);
    chk("cfg_t130_done", PRData[31], 0);
    chk("cfg_t130_busy", PRData[30], 1);
    chk("cfg_t130_cs", CS_, 1);
    step(1);
    chk("cfg_t131_prdata", PRData, 32'h8000_0000);
    chk("cfg_mosi_word", mosi_word, 32'h0000_2570);
    chk("cfg_rises", rise_cnt, 16);

    // CONVERT left
    miso_word = 16'hA5C3;
    do_write(32'h0000_8000);
    chk("cvl_done_clr", PRData[31], 0);
    step(59);
    chk("cvl_no_partial", PRData, 32'h4000_0000);
    step(71);
    chk("cvl_prdata", PRData, 32'h8000_A5C3);
    chk("cvl_mosi_word", mosi_word, 32'h0000_8000);

    // CONVERT right, back-to-back in the first IDLE cycle
    miso_word = 16'h1234;
    do_write(32'h0000_C000);
    chk("cvr_busy", PRData[30], 1);
    step(130);
    chk("cvr_prdata", PRData, 32'h8001_1234);
    chk("cvr_mosi_word", mosi_word, 32'h0000_C000);

    // Held write: accepts at t0 and t0+131 only
    miso_word = 16'h0F0F;
    n0 = cs_falls;
    t0 = cyc;
    PSel    = 1'b1;
    PEnable = 1'b1;
    PWrite  = 1'b1;
    PWData  = 32'h0000_8000;
    step(250);
    PSel    = 1'b0;
    PEnable = 1'b0;
    PWrite  = 1'b0;
    step(150);
    chk("held_pulses", cs_falls - n0, 2);
    chk("held_first_fall", prev_fall_cyc - t0, 1);
    chk("held_second_fall", last_fall_cyc - t0, 132);
    chk("held_prdata", PRData, 32'h8000_0F0F);

    // Reset at t+40 of a CONVERT
    miso_word = 16'hFFFF;
    do_write(32'h0000_8000);
    step(39);
    Reset = 1'b1;
    step(1);
    chk("mrst_cs", CS_, 1);
    chk("mrst_sclk", SClk, 0);
    chk("mrst_prdata", PRData, 32'h2000_0000);
    chk("mrst_pd", PowerDown, 1);
    Reset = 1'b0;
    miso_word = 16'h8001;
    do_write(32'h0000_C000);
    chk("post_rst_busy", PRData[30], 1);
    step(130);
    chk("post_rst_prdata", PRData, 32'hA001_8001);
    chk("post_rst_mosi", mosi_word, 32'h0000_C000);

    // POWER_DOWN with PowerDown already set
    r0 = total_rises;
    do_write(32'h4000_0000);
    chk("pdn_pd", PowerDown, 1);
    chk("pdn_busy", PRData[30], 1);
    chk("pdn_done_clr", PRData[31], 0);
    chk("pdn_cs", CS_, 1);
    step(1);
    chk("pdn_done", PRData, 32'hA001_8001);
    chk("pdn_no_sclk", total_rises - r0, 0);

    // Reserved command is ignored
    do_write(32'hC000_0000);
    chk("rsv_prdata", PRData, 32'hA001_8001);
    chk("rsv_cs", CS_, 1);
    step(5);
    chk("rsv_hold", PRData, 32'hA001_8001);
    chk("rsv_no_sclk", total_rises - r0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
